qsram_edge_sequencer: RTL and testbench
=======================================

// Module: qsram_edge_sequencer
// PURPOSE
//  Control stage directly upstream of the QSRAM cell array. Turns a valid/ready access
//  request stream into non-overlapping per-row WriteEdge/ReadEdge strobes. Issues
//  periodic round-robin RefreshEdge strobes so every row's latch is re-driven.
//  Captures read data from the array's shared read bus.
// PARAMETERS
//  DEPTH            16  rows of cells; address width AW = $clog2(DEPTH)
//  WIDTH            8   cells per row (bits per word)
//  PULSE_CYCLES     2   cycles each edge strobe is held high (>=1)
//  REFRESH_INTERVAL 64  cycles between refresh requests (>=PULSE_CYCLES+2)
// PORTS
//  Clock        in   1      single clock; all state updates on rising edge
//  Reset        in   1      synchronous, active-high
//  ReqValid     in   1      access request present
//  ReqReady     out  1      sequencer accepts request this cycle
//  ReqWrite     in   1      1 = write, 0 = read
//  ReqAddr      in   AW     target row
//  ReqData      in   WIDTH  write data
//  RespValid    out  1      one-cycle pulse: RespData valid
//  RespData     out  WIDTH  read result
//  WriteEdge    out  DEPTH  one-hot row write strobe
//  ReadEdge     out  DEPTH  one-hot row read strobe
//  RefreshEdge  out  DEPTH  one-hot row refresh strobe
//  WriteData    out  WIDTH  data driven to cell inputData during write strobe
//  CellData     in   WIDTH  shared read bus from array
//  RefreshMiss  out  1      one-cycle pulse: refresh interval expired while one still pending
// BEHAVIOUR
//  Reset: all strobes 0, WriteData 0, RespValid 0, RespData 0, ReqReady 0, RefreshMiss 0.
//   Reset also clears the timer, RefreshRow and RefreshPending. Next cycle: state IDLE.
//  FSM states: IDLE -> WRITE | READ | REFRESH -> RECOVER -> IDLE.
//  Timer counts 0..REFRESH_INTERVAL-1 and wraps. Terminal count sets RefreshPending (sticky).
//   Terminal count while already pending pulses RefreshMiss; pending stays set, not double-counted.
//  ReqReady = (state==IDLE) & ~RefreshPending & ~Reset. Accept = ReqValid & ReqReady.
//  IDLE with RefreshPending: refresh wins, even if ReqValid is high the same cycle.
//  Write accepted at cycle T:
//   - ReqData/ReqAddr registered at T.
//   - WriteEdge[addr]=1 for cycles T+1..T+P (P=PULSE_CYCLES); WriteData stable over that window.
//  Read accepted at T:
//   - ReadEdge[addr]=1 for cycles T+1..T+P.
//   - CellData sampled in cycle T+P.
//   - RespValid=1 with RespData at T+P+1, for one cycle. RespData holds until next read.
//  Refresh entered at T:
//   - RefreshEdge[RefreshRow]=1 for T+1..T+P; RefreshPending cleared at T+1.
//   - RefreshRow increments at end of pulse, wrapping DEPTH-1 -> 0.
//  RECOVER: one cycle with all strobes low, guaranteeing no two strobes overlap.
//   Next accept no earlier than T+P+2.
//  Terminal count in the same cycle as an accept: access proceeds; refresh is serviced
//   after RECOVER.
//  At most one bit set across WriteEdge|ReadEdge|RefreshEdge in any cycle.
//  Reset mid-operation: strobes low the next cycle; in-flight op discarded; no RespValid.
// CONFIGURATION
//  QSRAM_SWEEP_COUNT_EN defined:
//   - adds output SweepCount [15:0], reset 0.
//   - increments (wrapping) in the cycle RefreshRow wraps DEPTH-1 -> 0.
//  Not defined: port absent; no counter logic.
// STRUCTURE
//  Package qsram_seq_pkg:
//   - state enum {IDLE, WRITE, READ, REFRESH, RECOVER}
//   - localparam function for AW
//  Sub-module qsram_refresh_timer holds the interval counter, RefreshPending,
//   RefreshMiss generation and RefreshRow. It takes a Serviced input from the FSM.
//  Top holds the FSM, pulse counter, address/data registers and one-hot decode.
// TESTING
//  1. Reset release, write addr 3 data 8'hA5 (P=2): WriteEdge=16'h0008 for 2 cycles,
//     WriteData=8'hA5; ReqReady back after 4 cycles.
//  2. Read addr 3 with CellData=8'hA5 during pulse: ReadEdge=16'h0008 for 2 cycles;
//     RespValid at T+3 with RespData=8'hA5.
//  3. Idle 64*16 cycles: RefreshEdge walks rows 0..15 once, one row per 64 cycles;
//     SweepCount=1 when the macro is defined.
//  4. ReqValid held high across a refresh terminal count: refresh strobe is issued first;
//     request accepted after RECOVER; strobes never overlap.
//  5. REFRESH_INTERVAL=4 with back-to-back reads keeping FSM busy: RefreshMiss pulses;
//     only one refresh per pending.
//  6. Assert Reset in cycle T+1 of a read: all strobes 0 at T+2, no RespValid,
//     ReqReady=1 one cycle after Reset drops.

Source files
------------

// File: rtl/qsram_seq_pkg.sv
// Shared types and helpers for the QSRAM edge sequencer.
// Optional sweep counter port is enabled by QSRAM_SWEEP_COUNT_EN.
package qsram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    REFRESH,
    RECOVER
  } state_e;

  function automatic int aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/qsram_refresh_timer.sv
// Refresh interval timer, sticky pending flag, miss pulse and row pointer.
// QSRAM_SWEEP_COUNT_EN adds a full-sweep counter output.
module qsram_refresh_timer
  import qsram_seq_pkg::*;
#(
  parameter int DEPTH            = 16,
  parameter int REFRESH_INTERVAL = 64,
  localparam int AW              = aw(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          serviced_i,
  input  logic          row_adv_i,
  output logic          pending_o,
  output logic          miss_o,
`ifdef QSRAM_SWEEP_COUNT_EN
  output logic [15:0]   sweep_count_o,
`endif
  output logic [AW-1:0] row_o
);

  localparam int TW = aw(REFRESH_INTERVAL);

  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] row_q, row_d;
  logic          pending_q, pending_d;
  logic          miss_q, miss_d;
  logic          tc;
  logic          row_wrap;

  always_comb begin
    tc       = (timer_q == TW'(REFRESH_INTERVAL - 1));
    timer_d  = tc ? '0 : timer_q + 1'b1;
    // A request arriving while one is pending merges into it
    miss_d    = tc & pending_q;
    pending_d = pending_q ? ~serviced_i : tc;
    row_wrap  = row_adv_i & (row_q == AW'(DEPTH - 1));
    row_d     = row_q;
    if (row_adv_i) begin
      row_d = row_wrap ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      row_q     <= '0;
      pending_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
    end
  end

`ifdef QSRAM_SWEEP_COUNT_EN
  logic [15:0] sweep_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sweep_q <= '0;
    end else if (row_wrap) begin
      sweep_q <= sweep_q + 16'd1;
    end
  end

  assign sweep_count_o = sweep_q;
`endif

  assign pending_o = pending_q;
  assign miss_o    = miss_q;
  assign row_o     = row_q;

endmodule

// File: rtl/qsram_edge_sequencer.sv
// Access/refresh strobe sequencer in front of the QSRAM cell array.
// QSRAM_SWEEP_COUNT_EN adds sweep_count_o (full refresh sweeps).
module qsram_edge_sequencer
  import qsram_seq_pkg::*;
#(
  parameter int DEPTH            = 16,
  parameter int WIDTH            = 8,
  parameter int PULSE_CYCLES     = 2,
  parameter int REFRESH_INTERVAL = 64,
  localparam int AW              = aw(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [WIDTH-1:0] req_data_i,
  output logic             resp_valid_o,
  output logic [WIDTH-1:0] resp_data_o,
  output logic [DEPTH-1:0] write_edge_o,
  output logic [DEPTH-1:0] read_edge_o,
  output logic [DEPTH-1:0] refresh_edge_o,
  output logic [WIDTH-1:0] write_data_o,
  input  logic [WIDTH-1:0] cell_data_i,
`ifdef QSRAM_SWEEP_COUNT_EN
  output logic [15:0]      sweep_count_o,
`endif
  output logic             refresh_miss_o
);

  localparam int CW = aw(PULSE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             last;
  logic             accept;
  logic             serviced;
  logic             row_adv;
  logic             pending;
  logic [AW-1:0]    ref_row;
  logic [DEPTH-1:0] addr_hot;
  logic [DEPTH-1:0] row_hot;

  qsram_refresh_timer #(
    .DEPTH            (DEPTH),
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .serviced_i    (serviced),
    .row_adv_i     (row_adv),
    .pending_o     (pending),
    .miss_o        (refresh_miss_o),
`ifdef QSRAM_SWEEP_COUNT_EN
    .sweep_count_o (sweep_count_o),
`endif
    .row_o         (ref_row)
  );

  assign req_ready_o = (state_q == IDLE) & ~pending & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign last        = (cnt_q == CW'(PULSE_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    serviced = 1'b0;
    row_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Refresh has priority over a request in the same cycle
        if (pending) begin
          serviced = 1'b1;
          state_d  = REFRESH;
        end else if (accept) begin
          addr_d  = req_addr_i;
          state_d = req_write_i ? WRITE : READ;
          if (req_write_i) begin
            data_d = req_data_i;
          end
        end
      end
      WRITE, READ, REFRESH: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = RECOVER;
          if (state_q == READ) begin
            rdata_d  = cell_data_i;
            rvalid_d = 1'b1;
          end
          if (state_q == REFRESH) begin
            row_adv = 1'b1;
          end
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign addr_hot = DEPTH'(1) << addr_q;
  assign row_hot  = DEPTH'(1) << ref_row;

  assign write_edge_o   = (state_q == WRITE)   ? addr_hot : '0;
  assign read_edge_o    = (state_q == READ)    ? addr_hot : '0;
  assign refresh_edge_o = (state_q == REFRESH) ? row_hot  : '0;
  assign write_data_o   = data_q;
  assign resp_valid_o   = rvalid_q;
  assign resp_data_o    = rdata_q;

endmodule

// File: tb/tb_qsram_edge_sequencer.sv
// Random and directed stimulus on two sequencers (interval 64 and 4)
// checked against a transaction-timeline reference model.
module tb_qsram_edge_sequencer;

  localparam int P = 2;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       vin;
  logic       win;
  logic [3:0] ain;
  logic [7:0] din;
  logic [7:0] cd;

  logic [1:0]       rdy, rvo, mso;
  logic [1:0][7:0]  rdo, wdo;
  logic [1:0][15:0] weo, reo, feo;
`ifdef QSRAM_SWEEP_COUNT_EN
  logic [1:0][15:0] swc;
`endif

  always #5 clk = ~clk;

  qsram_edge_sequencer #(
    .DEPTH(D), .WIDTH(8), .PULSE_CYCLES(P), .REFRESH_INTERVAL(64)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(vin), .req_ready_o(rdy[0]),
    .req_write_i(win), .req_addr_i(ain), .req_data_i(din),
    .resp_valid_o(rvo[0]), .resp_data_o(rdo[0]),
    .write_edge_o(weo[0]), .read_edge_o(reo[0]),
    .refresh_edge_o(feo[0]), .write_data_o(wdo[0]),
    .cell_data_i(cd),
`ifdef QSRAM_SWEEP_COUNT_EN
    .sweep_count_o(swc[0]),
`endif
    .refresh_miss_o(mso[0])
  );

  qsram_edge_sequencer #(
    .DEPTH(D), .WIDTH(8), .PULSE_CYCLES(P), .REFRESH_INTERVAL(4)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(vin), .req_ready_o(rdy[1]),
    .req_write_i(win), .req_addr_i(ain), .req_data_i(din),
    .resp_valid_o(rvo[1]), .resp_data_o(rdo[1]),
    .write_edge_o(weo[1]), .read_edge_o(reo[1]),
    .refresh_edge_o(feo[1]), .write_data_o(wdo[1]),
    .cell_data_i(cd),
`ifdef QSRAM_SWEEP_COUNT_EN
    .sweep_count_o(swc[1]),
`endif
    .refresh_miss_o(mso[1])
  );

  int vecs = 0;
  int errs = 0;
  int n    = 0;
  int ival [2] = '{64, 4};

  // Model: timeline of operations (kind 1=W 2=R 3=F), start = decision cycle
  int       idle_at [2];
  int       op_k    [2];
  int       op_s    [2];
  int       op_r    [2];
  int       rrow    [2];
  int       sweep   [2];
  bit       pend    [2];
  bit       rv      [2];
  bit       miss    [2];
  logic [7:0] wd    [2];
  logic [7:0] rd    [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic mreset(input int k);
    idle_at[k] = 0; op_k[k] = 0; op_s[k] = 0; op_r[k] = 0;
    rrow[k] = 0; sweep[k] = 0; pend[k] = 0; rv[k] = 0;
    miss[k] = 0; wd[k] = 8'h00; rd[k] = 8'h00;
  endtask

  task automatic step();
    logic [15:0] e_we, e_re, e_fe;
    bit act, srv, tc, nrv;
    string s;
    for (int k = 0; k < 2; k++) begin
      s = $sformatf("%0d", k);
      if (rst) begin
        chk({"ready_in_reset", s}, 32'(rdy[k]), 0);
        mreset(k);
      end else begin
        act  = op_k[k] != 0 && n > op_s[k] && n <= op_s[k] + P;
        e_we = (act && op_k[k] == 1) ? 16'(1) << op_r[k] : 16'h0;
        e_re = (act && op_k[k] == 2) ? 16'(1) << op_r[k] : 16'h0;
        e_fe = (act && op_k[k] == 3) ? 16'(1) << op_r[k] : 16'h0;
        chk({"write_edge", s}, 32'(weo[k]), 32'(e_we));
        chk({"read_edge", s}, 32'(reo[k]), 32'(e_re));
        chk({"refresh_edge", s}, 32'(feo[k]), 32'(e_fe));
        chk({"write_data", s}, 32'(wdo[k]), 32'(wd[k]));
        chk({"resp_valid", s}, 32'(rvo[k]), 32'(rv[k]));
        chk({"resp_data", s}, 32'(rdo[k]), 32'(rd[k]));
        chk({"req_ready", s}, 32'(rdy[k]),
            32'(n >= idle_at[k] && !pend[k]));
        chk({"refresh_miss", s}, 32'(mso[k]), 32'(miss[k]));
        chk({"one_strobe", s},
            32'($countones(weo[k] | reo[k] | feo[k]) <= 1), 1);
`ifdef QSRAM_SWEEP_COUNT_EN
        chk({"sweep_count", s}, 32'(swc[k]), 32'(sweep[k] % 65536));
`endif
        nrv = op_k[k] == 2 && n == op_s[k] + P;
        if (nrv) rd[k] = cd;
        rv[k] = nrv;
        if (op_k[k] == 3 && n == op_s[k] + P) begin
          if (rrow[k] == D - 1) begin
            rrow[k] = 0;
            sweep[k]++;
          end else begin
            rrow[k]++;
          end
        end
        srv = 0;
        if (n >= idle_at[k]) begin
          if (pend[k]) begin
            op_k[k] = 3; op_r[k] = rrow[k]; op_s[k] = n;
            idle_at[k] = n + P + 2;
            srv = 1;
          end else if (vin) begin
            op_k[k] = win ? 1 : 2; op_r[k] = int'(ain); op_s[k] = n;
            idle_at[k] = n + P + 2;
            if (win) wd[k] = din;
          end
        end
        tc = (n % ival[k]) == ival[k] - 1;
        miss[k] = tc && pend[k];
        pend[k] = pend[k] ? !srv : tc;
      end
    end
    n = rst ? 0 : n + 1;
  endtask

  task automatic cyc(input bit r, input bit v, input bit w,
                     input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] c);
    rst = r; vin = v; win = w; ain = a; din = d; cd = c;
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) cyc(0, 0, 0, 4'h0, 8'h00, 8'($urandom));
  endtask

  initial begin
    rst = 1'b1; vin = 0; win = 0; ain = 0; din = 0; cd = 0;
    repeat (3) cyc(1, 0, 0, 4'h0, 8'h00, 8'h00);
    cyc(0, 1, 1, 4'd3, 8'hA5, 8'h00);
    idle(5);
    cyc(0, 1, 0, 4'd3, 8'h00, 8'h00);
    repeat (2) cyc(0, 0, 0, 4'h0, 8'h00, 8'hA5);
    idle(4);
    idle(64 * 16 + 8);
    repeat (300) cyc(0, 1, 1'($urandom), 4'($urandom),
                     8'($urandom), 8'($urandom));
    repeat (2000) cyc(0, ($urandom % 4) != 0, 1'($urandom),
                      4'($urandom), 8'($urandom), 8'($urandom));
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 80 && !(n >= idle_at[0] && !pend[0]); i++)
        idle(1);
      cyc(0, 1, 0, 4'($urandom), 8'h00, 8'($urandom));
      cyc(1, 0, 0, 4'h0, 8'h00, 8'($urandom));
      idle(6);
      repeat (150) cyc(0, ($urandom % 3) != 0, 1'($urandom),
                       4'($urandom), 8'($urandom), 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
